rgmii_tx_ddr_fmt: RTL and testbench

- Transmit-side counterpart of the source-synchronous DDR input path.
- Converts the MAC's GMII transmit stream (8-bit SDR) into RGMII DDR half-cycle pairs for 1000/100/10 Mb/s.
- Generates the MAC clock enable and the forwarded-clock bit pattern.
- Outputs feed a generic ODDR stage (q1 = rising half, q2 = falling half), all on one 125 MHz clock.

---
 rtl/rgmii_tx_ddr_fmt.sv | 188 ++++++++++++++++++
 tb/tb_rgmii_tx_ddr_fmt.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/rgmii_tx_ddr_fmt.sv
// RGMII transmit formatter: turns the MAC's 8-bit SDR GMII stream into
// rising/falling half-cycle pairs for a generic ODDR stage, generates the
// MAC clock enable and the forwarded-clock bit pattern for 1000/100/10 Mb/s.
// Everything runs on the single 125 MHz clk; all outputs are registered.
module rgmii_tx_ddr_fmt #(
  parameter int CNT_100 = 5,   // clk cycles per RGMII clock period at 100 Mb/s
  parameter int CNT_10  = 50   // clk cycles per RGMII clock period at 10 Mb/s
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       mac_gmii_tx_clk_en,
  output logic [3:0] txd_q1,
  output logic [3:0] txd_q2,
  output logic       tx_ctl_q1,
  output logic       tx_ctl_q2,
  output logic       tx_clk_q1,
  output logic       tx_clk_q2
);

  typedef enum logic [1:0] {
    M10   = 2'd0,
    M100  = 2'd1,
    M1000 = 2'd2
  } mode_t;

  localparam int CNT_MAX = (CNT_10 > CNT_100) ? CNT_10 : CNT_100;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] LAST_100 = CW'(CNT_100 - 1);
  localparam logic [CW-1:0] LAST_10  = CW'(CNT_10 - 1);
  localparam logic [CW-1:0] HALF_100 = CW'(CNT_100 / 2);
  localparam logic [CW-1:0] HALF_10  = CW'(CNT_10 / 2);
  localparam logic          ODD_100  = (CNT_100 % 2) == 1;
  localparam logic          ODD_10   = (CNT_10 % 2) == 1;

  // State
  mode_t         speed_reg;
  logic [CW-1:0] cnt;
  logic          phase;
  logic [7:0]    tx_byte;
  logic          tx_en;
  logic          tx_er;

  // Next-state values
  mode_t         speed_mode;
  mode_t         speed_d;
  logic [CW-1:0] cnt_d;
  logic          phase_d;
  logic [7:0]    tx_byte_d;
  logic          tx_en_d;
  logic          tx_er_d;
  logic          clk_en_d;
  logic [3:0]    txd_q1_d;
  logic [3:0]    txd_q2_d;
  logic          tx_clk_q1_d;
  logic          tx_clk_q2_d;
  logic [CW-1:0] last;
  logic [CW-1:0] half;
  logic          odd;
  logic [3:0]    nib;

  // Decode the requested speed; 2'b11 and 2'b10 both mean 1000 Mb/s so
  // flipping between them never looks like a speed change.
  always_comb begin
    unique case (speed)
      2'b00:   speed_mode = M10;
      2'b01:   speed_mode = M100;
      default: speed_mode = M1000;
    endcase
  end

  // Next-state and next-output logic. Outputs are computed from the next
  // state so that the registered outputs line up with the registered
  // cnt/phase/byte of the same cycle (one cycle after GMII sampling).
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    speed_d     = speed_mode;
    cnt_d       = '0;
    phase_d     = 1'b0;
    tx_byte_d   = '0;
    tx_en_d     = 1'b0;
    tx_er_d     = 1'b0;
    clk_en_d    = 1'b0;
    txd_q1_d    = '0;
    txd_q2_d    = '0;
    tx_clk_q1_d = 1'b0;
    tx_clk_q2_d = 1'b0;
    nib         = '0;

    last = (speed_d == M100) ? LAST_100 : LAST_10;
    half = (speed_d == M100) ? HALF_100 : HALF_10;
    odd  = (speed_d == M100) ? ODD_100  : ODD_10;

    if (speed_mode == speed_reg) begin
      // Capture the GMII inputs only at the end of a clock-enable cycle.
      if (mac_gmii_tx_clk_en) begin
        tx_byte_d = gmii_txd;
        tx_en_d   = gmii_tx_en;
        tx_er_d   = gmii_tx_er;
      end else begin
        tx_byte_d = tx_byte;
        tx_en_d   = tx_en;
        tx_er_d   = tx_er;
      end

      if (speed_reg == M1000) begin
        clk_en_d = 1'b1;
      end else begin
        if (cnt == last) begin
          cnt_d   = '0;
          phase_d = ~phase;
        end else begin
          cnt_d   = cnt + 1'b1;
          phase_d = phase;
        end
        // One enable per two RGMII periods, in the last cycle of phase 1,
        // so the new byte is captured exactly as cnt wraps to phase 0.
        clk_en_d = (cnt_d == last) && phase_d;
      end
    end
    // On a speed change all counters, the captured byte and the enable
    // stay at their cleared defaults: the new mode starts as after reset.

    if (speed_d == M1000) begin
      txd_q1_d    = tx_byte_d[3:0];
      txd_q2_d    = tx_byte_d[7:4];
      tx_clk_q1_d = 1'b1;
      tx_clk_q2_d = 1'b0;
    end else begin
      nib      = phase_d ? tx_byte_d[7:4] : tx_byte_d[3:0];
      txd_q1_d = nib;
      txd_q2_d = nib;
      // Low first half, high second half: the rising edge lands mid-period,
      // centred on the data. An odd period splits the middle cycle.
      if (cnt_d < half) begin
        tx_clk_q1_d = 1'b0;
        tx_clk_q2_d = 1'b0;
      end else if ((cnt_d == half) && odd) begin
        tx_clk_q1_d = 1'b0;
        tx_clk_q2_d = 1'b1;
      end else begin
        tx_clk_q1_d = 1'b1;
        tx_clk_q2_d = 1'b1;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      speed_reg          <= M1000;
      cnt                <= '0;
      phase              <= 1'b0;
      tx_byte            <= '0;
      tx_en              <= 1'b0;
      tx_er              <= 1'b0;
      mac_gmii_tx_clk_en <= 1'b0;
      txd_q1             <= '0;
      txd_q2             <= '0;
      tx_ctl_q1          <= 1'b0;
      tx_ctl_q2          <= 1'b0;
      tx_clk_q1          <= 1'b0;
      tx_clk_q2          <= 1'b0;
    end else begin
      speed_reg          <= speed_d;
      cnt                <= cnt_d;
      phase              <= phase_d;
      tx_byte            <= tx_byte_d;
      tx_en              <= tx_en_d;
      tx_er              <= tx_er_d;
      mac_gmii_tx_clk_en <= clk_en_d;
      txd_q1             <= txd_q1_d;
      txd_q2             <= txd_q2_d;
      tx_ctl_q1          <= tx_en_d;
      tx_ctl_q2          <= tx_en_d ^ tx_er_d;
      tx_clk_q1          <= tx_clk_q1_d;
      tx_clk_q2          <= tx_clk_q2_d;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_ddr_fmt.sv
// Self-checking bench for rgmii_tx_ddr_fmt: a 1000 Mb/s vector table plus
// hand-written 100/10 Mb/s, speed-change and reset sequences.
// Outputs are packed as {clk_en, txd_q1, txd_q2, ctl_q1, ctl_q2, clk_q1, clk_q2}.
module tb_rgmii_tx_ddr_fmt;

  logic       clk;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en;
  logic       gmii_tx_er;
  logic       mac_gmii_tx_clk_en;
  logic [3:0] txd_q1;
  logic [3:0] txd_q2;
  logic       tx_ctl_q1;
  logic       tx_ctl_q2;
  logic       tx_clk_q1;
  logic       tx_clk_q2;

  int checks = 0;
  int errors = 0;

  rgmii_tx_ddr_fmt #(.CNT_100(5), .CNT_10(50)) dut (
    .clk                (clk),
    .rst                (rst),
    .speed              (speed),
    .gmii_txd           (gmii_txd),
    .gmii_tx_en         (gmii_tx_en),
    .gmii_tx_er         (gmii_tx_er),
    .mac_gmii_tx_clk_en (mac_gmii_tx_clk_en),
    .txd_q1             (txd_q1),
    .txd_q2             (txd_q2),
    .tx_ctl_q1          (tx_ctl_q1),
    .tx_ctl_q2          (tx_ctl_q2),
    .tx_clk_q1          (tx_clk_q1),
    .tx_clk_q2          (tx_clk_q2)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  typedef struct {
    logic [7:0]  txd;
    logic        en;
    logic        er;
    logic [12:0] exp;
  } vec_t;

  function automatic logic [12:0] mk(input logic ce, input logic [3:0] q1,
                                     input logic [3:0] q2, input logic c1,
                                     input logic c2, input logic k1,
                                     input logic k2);
    return {ce, q1, q2, c1, c2, k1, k2};
  endfunction

  function automatic logic [12:0] outs();
    return {mac_gmii_tx_clk_en, txd_q1, txd_q2, tx_ctl_q1, tx_ctl_q2,
            tx_clk_q1, tx_clk_q2};
  endfunction

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %04h expected %04h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic e, input logic r);
    gmii_txd   = d;
    gmii_tx_en = e;
    gmii_tx_er = r;
  endtask

  // Forwarded-clock pattern for a 5-cycle period.
  function automatic logic [1:0] clk100(input int m);
    case (m)
      0, 1:    return 2'b00;
      2:       return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // Entered at the falling edge of cycle 0 of 100 Mb/s mode (first cycle
  // after the resync edge). MAC presents 0x5D, then 0x7E with er from cycle 10.
  task automatic run_100_seq(input string tag);
    logic [3:0] nb;
    logic       c1, c2, ce;
    logic [1:0] k;
    drive(8'h5D, 1'b1, 1'b0);
    for (int c = 0; c < 30; c++) begin
      if (c > 0) @(negedge clk);
      ce = (c == 9) || (c == 19) || (c == 29);
      k  = clk100(c % 5);
      if (c < 10)      begin nb = 4'h0; c1 = 1'b0; c2 = 1'b0; end
      else if (c < 15) begin nb = 4'hD; c1 = 1'b1; c2 = 1'b1; end
      else if (c < 20) begin nb = 4'h5; c1 = 1'b1; c2 = 1'b1; end
      else if (c < 25) begin nb = 4'hE; c1 = 1'b1; c2 = 1'b0; end
      else             begin nb = 4'h7; c1 = 1'b1; c2 = 1'b0; end
      check($sformatf("%s_cyc%0d", tag, c), outs(), mk(ce, nb, nb, c1, c2, k[1], k[0]));
      if (c == 10) drive(8'h7E, 1'b1, 1'b1);
    end
  endtask

  vec_t vecs[6];

  initial begin
    logic [3:0] nb;
    logic       c1, ce;
    logic [1:0] k;

    vecs[0] = '{8'hA5, 1'b1, 1'b0, mk(1'b1, 4'h5, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0)};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, mk(1'b1, 4'hC, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0)};
    vecs[2] = '{8'h00, 1'b0, 1'b1, mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0)};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, mk(1'b1, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0)};
    vecs[4] = '{8'h81, 1'b1, 1'b0, mk(1'b1, 4'h1, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0)};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, mk(1'b1, 4'hE, 4'h7, 1'b1, 1'b0, 1'b1, 1'b0)};

    rst   = 1'b1;
    speed = 2'b10;
    drive(8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset_state", outs(), 13'h0000);

    // First cycle after release in 1000 mode: enable up, no byte yet.
    rst = 1'b0;
    @(negedge clk);
    check("g1000_first", outs(), mk(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].txd, vecs[i].en, vecs[i].er);
      @(negedge clk);
      check($sformatf("g1000_vec%0d", i), outs(), vecs[i].exp);
    end

    // 2'b10 <-> 2'b11 must not disturb the stream.
    speed = 2'b11;
    drive(8'h5A, 1'b1, 1'b0);
    @(negedge clk);
    check("spd_11", outs(), mk(1'b1, 4'hA, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0));
    speed = 2'b10;
    drive(8'hC3, 1'b1, 1'b0);
    @(negedge clk);
    check("spd_10", outs(), mk(1'b1, 4'h3, 4'hC, 1'b1, 1'b1, 1'b1, 1'b0));

    // 1000 -> 100 mid-frame: everything cleared, then reset-like timing.
    speed = 2'b01;
    @(negedge clk);
    run_100_seq("sw100");

    // Reset during phase 1 of 100 mode (cycle 36 = cnt 1, phase 1).
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame", outs(), 13'h0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_100_seq("rst100");

    // 100 -> 10: byte 0xF0 gives nibble 0x0 then 0xF, 50 cycles each.
    speed = 2'b00;
    drive(8'hF0, 1'b1, 1'b0);
    @(negedge clk);
    for (int c = 0; c < 200; c++) begin
      if (c > 0) @(negedge clk);
      ce = (c == 99) || (c == 199);
      k  = ((c % 50) < 25) ? 2'b00 : 2'b11;
      if (c < 100)      begin nb = 4'h0; c1 = 1'b0; end
      else if (c < 150) begin nb = 4'h0; c1 = 1'b1; end
      else              begin nb = 4'hF; c1 = 1'b1; end
      check($sformatf("m10_cyc%0d", c), outs(), mk(ce, nb, nb, c1, c1, k[1], k[0]));
      if (c == 100) drive(8'h00, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
